// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter between instruction fetch and the load/store path.
// Multi-byte transfers go out one byte per cycle; read data is assembled little-endian.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] IO_BASE      = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        flush,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic [31:0] d_rdata,
    input  logic [7:0]  ram_din,
    input  logic        io_buffer_full,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_addr,
    output logic        ram_wr
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_RTAIL, S_WRITE} state_e;

    state_e         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [2:0]     nbytes_q, nbytes_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic [31:0]    base_q, base_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    asm_q, asm_d;
    logic           sgn_q, sgn_d;
    logic           fetch_q, fetch_d;
    logic           if_done_q, if_done_d;
    logic [31:0]    if_data_q, if_data_d;
    logic           d_done_q, d_done_d;
    logic [31:0]    d_rdata_q, d_rdata_d;
    logic [31:0]    ram_addr_q, ram_addr_d;
    logic [7:0]     ram_dout_q, ram_dout_d;
    logic           ram_wr_q, ram_wr_d;

    logic [31:0]    byte_addr;
    logic [31:0]    asm_full;
    logic [1:0]     prev_lane;
    logic           fetch_wins;

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] n,
                                           input logic s);
        case (n)
            3'd1:    return {{24{s & w[7]}}, w[7:0]};
            3'd2:    return {{16{s & w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Outputs are computed from next-state values so every port comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        nbytes_d   = nbytes_q;
        starve_d   = starve_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        sgn_d      = sgn_q;
        fetch_d    = fetch_q;
        if_done_d  = 1'b0;
        if_data_d  = if_data_q;
        d_done_d   = 1'b0;
        d_rdata_d  = d_rdata_q;
        ram_addr_d = '0;
        ram_dout_d = '0;
        ram_wr_d   = 1'b0;

        byte_addr  = base_q + {29'd0, idx_q};
        prev_lane  = idx_q[1:0] - 2'd1;
        asm_full   = asm_q;
        asm_full[{idx_q[1:0], 3'b000} +: 8] = ram_din;
        fetch_wins = if_req && !flush && (!d_req || (starve_q >= SW'(STARVE_LIMIT)));

        if (!if_req) begin
            starve_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                // The done cycle never grants, so a requester still holding its request is not re-served.
                if (!if_done_q && !d_done_q) begin
                    if (fetch_wins) begin
                        state_d    = S_READ;
                        base_d     = if_addr;
                        nbytes_d   = 3'd4;
                        sgn_d      = 1'b0;
                        fetch_d    = 1'b1;
                        idx_d      = 3'd0;
                        starve_d   = '0;
                        ram_addr_d = if_addr;
                    end else if (d_req) begin
                        base_d   = d_addr;
                        wdata_d  = d_wdata;
                        sgn_d    = d_signed;
                        fetch_d  = 1'b0;
                        idx_d    = 3'd0;
                        case (d_size)
                            2'd0:    nbytes_d = 3'd1;
                            2'd1:    nbytes_d = 3'd2;
                            default: nbytes_d = 3'd4;
                        endcase
                        if (if_req && (starve_q < SW'(STARVE_LIMIT))) begin
                            starve_d = starve_q + SW'(1);
                        end
                        ram_addr_d = d_addr;
                        if (!d_we) begin
                            state_d = S_READ;
                        end else begin
                            state_d = S_WRITE;
                            if (!((d_addr >= IO_BASE) && io_buffer_full)) begin
                                ram_wr_d   = 1'b1;
                                ram_dout_d = d_wdata[7:0];
                                idx_d      = 3'd1;
                            end
                        end
                    end
                end
            end

            S_READ: begin
                if (fetch_q && flush) begin
                    state_d = S_IDLE;
                    idx_d   = 3'd0;
                end else begin
                    if (idx_q != 3'd0) begin
                        asm_d[{prev_lane, 3'b000} +: 8] = ram_din;
                    end
                    if (idx_q == nbytes_q - 3'd1) begin
                        state_d = S_RTAIL;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        ram_addr_d = byte_addr + 32'd1;
                    end
                end
            end

            S_RTAIL: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
                if (!(fetch_q && flush)) begin
                    asm_d = asm_full;
                    if (fetch_q) begin
                        if_done_d = 1'b1;
                        if_data_d = asm_full;
                    end else begin
                        d_done_d  = 1'b1;
                        d_rdata_d = extend(asm_full, nbytes_q, sgn_q);
                    end
                end
            end

            S_WRITE: begin
                // idx counts bytes already placed on the bus.
                if (idx_q == nbytes_q) begin
                    state_d  = S_IDLE;
                    idx_d    = 3'd0;
                    d_done_d = 1'b1;
                end else begin
                    ram_addr_d = byte_addr;
                    if (!((byte_addr >= IO_BASE) && io_buffer_full)) begin
                        ram_wr_d   = 1'b1;
                        ram_dout_d = wdata_q[{idx_q[1:0], 3'b000} +: 8];
                        idx_d      = idx_q + 3'd1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            nbytes_q   <= '0;
            starve_q   <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
            sgn_q      <= 1'b0;
            fetch_q    <= 1'b0;
            if_done_q  <= 1'b0;
            if_data_q  <= '0;
            d_done_q   <= 1'b0;
            d_rdata_q  <= '0;
            ram_addr_q <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            nbytes_q   <= nbytes_d;
            starve_q   <= starve_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            sgn_q      <= sgn_d;
            fetch_q    <= fetch_d;
            if_done_q  <= if_done_d;
            if_data_q  <= if_data_d;
            d_done_q   <= d_done_d;
            d_rdata_q  <= d_rdata_d;
            ram_addr_q <= ram_addr_d;
            ram_dout_q <= ram_dout_d;
            ram_wr_q   <= ram_wr_d;
        end
    end

    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign d_done   = d_done_q;
    assign d_rdata  = d_rdata_q;
    assign ram_addr = ram_addr_q;
    assign ram_dout = ram_dout_q;
    assign ram_wr   = ram_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte-wide RAM model, expected-result queue, grant-order checks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        flush = 1'b0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = '0;
    logic        d_signed = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic [7:0]  ram_din = '0;
    logic        io_buffer_full = 1'b0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_addr;
    logic        ram_wr;

    mem_arbiter #(.STARVE_LIMIT(4), .IO_BASE(32'h0003_0000)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .flush(flush),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
        .ram_din(ram_din), .io_buffer_full(io_buffer_full),
        .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    bit   [7:0]  wmem [bit [31:0]];

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            32'h200: return 8'h80;
            32'h210: return 8'h34;
            32'h211: return 8'hF2;
            32'h220: return 8'h78;
            32'h221: return 8'h56;
            32'h222: return 8'h34;
            32'h223: return 8'h12;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] wb(input logic [31:0] a);
        return wmem.exists(a) ? wmem[a] : 8'h00;
    endfunction

    function automatic logic [31:0] wword(input logic [31:0] a);
        return {wb(a + 32'd3), wb(a + 32'd2), wb(a + 32'd1), wb(a)};
    endfunction

    // RAM model: read byte valid the cycle after its address.
    always @(posedge clk) begin
        if (ram_wr) wmem[ram_addr] = ram_dout;
        ram_din <= wmem.exists(ram_addr) ? wmem[ram_addr] : rom(ram_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input bit is_fetch, output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (is_fetch ? if_done : d_done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] exp, input int exp_lat);
        int lat;
        d_req = 1'b1; d_we = 1'b0; d_size = size; d_signed = sgn; d_addr = addr;
        exp_q.push_back(exp);
        wait_done(1'b0, lat);
        d_req = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check(tag, d_rdata, exp_q.pop_front());
        @(negedge clk);
        check({tag, "_pulse"}, 32'(d_done), 32'd0);
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        int lat;
        if_req = 1'b1; if_addr = addr;
        exp_q.push_back(exp);
        wait_done(1'b1, lat);
        if_req = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'd6);
        check(tag, if_data, exp_q.pop_front());
        @(negedge clk);
        check({tag, "_pulse"}, 32'(if_done), 32'd0);
    endtask

    initial begin
        int          lat;
        int          stalls;
        int          dones;
        int          done_at;
        int          wr_cnt;
        int          first_seen;
        logic [31:0] first_addr;
        logic [31:0] first_dout;
        logic [31:0] wr_log[$];
        logic [31:0] exp_wr[4];
        int          seq[$];
        int          pat[6];

        repeat (2) @(negedge clk);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_ram_wr", 32'(ram_wr), 32'd0);
        check("rst_ram_dout", 32'(ram_dout), 32'd0);
        check("rst_if_done", 32'(if_done), 32'd0);
        check("rst_d_done", 32'(d_done), 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Fetch: consecutive byte addresses, done six cycles after the grant
        if_req = 1'b1; if_addr = 32'h100;
        exp_q.push_back(32'h0010_0513);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("fetch_addr%0d", i), ram_addr, 32'h100 + 32'(i));
        end
        wait_done(1'b1, lat);
        if_req = 1'b0;
        check("fetch_lat", 32'(lat + 4), 32'd6);
        check("fetch_data", if_data, exp_q.pop_front());
        @(negedge clk);
        check("fetch_pulse", 32'(if_done), 32'd0);

        do_load("lb_s", 32'h200, 2'd0, 1'b1, 32'hFFFF_FF80, 3);
        do_load("lb_u", 32'h200, 2'd0, 1'b0, 32'h0000_0080, 3);
        do_load("lh_s", 32'h210, 2'd1, 1'b1, 32'hFFFF_F234, 4);
        do_load("lh_u", 32'h210, 2'd1, 1'b0, 32'h0000_F234, 4);
        do_load("lw", 32'h220, 2'd2, 1'b1, 32'h1234_5678, 6);
        do_load("lw_sz3", 32'h220, 2'd3, 1'b0, 32'h1234_5678, 6);

        // IO store with back-pressure after the second byte
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 32'h0003_0000; d_wdata = 32'hDEAD_BEEF;
        stalls = 0; dones = 0; done_at = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ram_wr) wr_log.push_back({24'd0, ram_dout});
            else if (i <= 7) stalls++;
            if (d_done) begin
                dones++;
                if (done_at == 0) done_at = i;
                d_req = 1'b0;
            end
            if (i == 2) io_buffer_full = 1'b1;
            if (i == 5) io_buffer_full = 1'b0;
        end
        exp_wr = '{32'hEF, 32'hBE, 32'hAD, 32'hDE};
        check("sw_wr_count", 32'(wr_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sw_byte%0d", k), (k < wr_log.size()) ? wr_log[k] : 32'hX, exp_wr[k]);
        end
        check("sw_stalls", 32'(stalls), 32'd3);
        check("sw_done_at", 32'(done_at), 32'd8);
        check("sw_done_cnt", 32'(dones), 32'd1);
        check("sw_mem", wword(32'h0003_0000), 32'hDEAD_BEEF);

        // Both requesters held: four data grants, then fetch is forced through
        d_we = 1'b0; d_size = 2'd0; d_signed = 1'b0; d_addr = 32'h200; d_req = 1'b1;
        if_req = 1'b1; if_addr = 32'h100;
        for (int i = 0; i < 300 && seq.size() < 6; i++) begin
            @(negedge clk);
            if (d_done) seq.push_back(0);
            if (if_done) begin
                seq.push_back(1);
                check("starve_fdata", if_data, 32'h0010_0513);
            end
        end
        d_req = 1'b0; if_req = 1'b0;
        pat = '{0, 0, 0, 0, 1, 0};
        check("starve_cnt", 32'(seq.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("grant%0d", k), (k < seq.size()) ? 32'(seq[k]) : 32'hX, 32'(pat[k]));
        end
        repeat (2) @(negedge clk);

        // Flush two cycles into a fetch cancels it
        if_req = 1'b1; if_addr = 32'h100;
        dones = 0; wr_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (if_done) dones++;
            if (ram_wr) wr_cnt++;
            if (i == 2) begin flush = 1'b1; if_req = 1'b0; end
            if (i == 3) begin
                flush = 1'b0;
                check("flush_addr_idle", ram_addr, 32'd0);
            end
        end
        check("flush_no_done", 32'(dones), 32'd0);
        check("flush_no_wr", 32'(wr_cnt), 32'd0);
        do_fetch("refetch", 32'h100, 32'h0010_0513);

        // Flush does not disturb a store
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 32'h400; d_wdata = 32'h1122_3344;
        dones = 0; done_at = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 2) flush = 1'b1;
            if (i == 3) flush = 1'b0;
            if (d_done) begin
                dones++;
                if (done_at == 0) done_at = i;
                d_req = 1'b0;
            end
        end
        check("flush_st_done_at", 32'(done_at), 32'd5);
        check("flush_st_done_cnt", 32'(dones), 32'd1);
        check("flush_st_mem", wword(32'h400), 32'h1122_3344);

        // Asynchronous reset in the middle of a store
        d_addr = 32'h500; d_wdata = 32'hCAFE_F00D; d_req = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_ram_wr", 32'(ram_wr), 32'd0);
        check("arst_ram_addr", ram_addr, 32'd0);
        check("arst_ram_dout", 32'(ram_dout), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        first_seen = 0; first_addr = '0; first_dout = '0; done_at = 0; dones = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ram_wr && first_seen == 0) begin
                first_seen = 1;
                first_addr = ram_addr;
                first_dout = {24'd0, ram_dout};
            end
            if (d_done) begin
                dones++;
                if (done_at == 0) done_at = i;
                d_req = 1'b0;
            end
        end
        check("arst_first_addr", first_addr, 32'h500);
        check("arst_first_byte", first_dout, 32'h0D);
        check("arst_done_at", 32'(done_at), 32'd5);
        check("arst_done_cnt", 32'(dones), 32'd1);
        check("arst_mem", wword(32'h500), 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
